// File: rtl/seqdet_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
// Reset defaults reproduce the legacy overlapping "1001" detector.
package seqdet_pkg;

    localparam logic [3:0]  SEQDET_DEF_PATTERN = 4'b1001;
    localparam int unsigned SEQDET_DEF_LEN     = 4;
    localparam logic        SEQDET_DEF_OVERLAP = 1'b1;

    // Length 0 is treated as 1; anything above the hardware limit is capped.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        int unsigned res;
        if (len == 0)
            res = 1;
        else if (len > max_len)
            res = max_len;
        else
            res = len;
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param_moore.sv
// Programmable serial pattern detector, Moore output, overlap/non-overlap modes.
// Optional saturating match counter built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param_moore
    import seqdet_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 8,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic               i_in_valid,
    input  logic               i_x,
    output logic               o_match
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_match_cnt
`endif
);

    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
        $error("seq_detector_param_moore: MAX_LEN must be 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detector_param_moore: CNT_W must be 1..32");
    end

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match;

    logic [MAX_LEN-1:0] w_pattern_n;
    logic [LEN_W-1:0]   w_len_n;
    logic               w_overlap_n;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic               w_match_n;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_shift_hist;
    logic [LEN_W-1:0]   w_shift_fill;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;

    assign w_accept = i_in_valid && !i_cfg_load;

    // Compare only the youngest r_len bits, and only once that many are valid.
    always_comb begin
        w_shift_hist = {r_hist[MAX_LEN-2:0], i_x};
        w_shift_fill = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_len;
        w_mask       = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (LEN_W'(i) < r_len);
        w_hit = (w_shift_fill == r_len) && (((w_shift_hist ^ r_pattern) & w_mask) == '0);
    end

    always_comb begin
        w_pattern_n = r_pattern;
        w_len_n     = r_len;
        w_overlap_n = r_overlap;
        w_hist_n    = r_hist;
        w_fill_n    = r_fill;
        w_match_n   = r_match;
        if (i_cfg_load) begin
            w_pattern_n = i_cfg_pattern;
            w_len_n     = LEN_W'(clamp_len(32'(i_cfg_len), MAX_LEN));
            w_overlap_n = i_cfg_overlap;
            w_hist_n    = '0;
            w_fill_n    = '0;
            w_match_n   = 1'b0;
        end else if (w_accept) begin
            w_hist_n  = w_shift_hist;
            w_match_n = w_hit;
            // Non-overlap keeps hist but restarts the fill count, so old bits can never complete a match.
            w_fill_n  = (w_hit && !r_overlap) ? '0 : w_shift_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= MAX_LEN'(SEQDET_DEF_PATTERN);
            r_len     <= LEN_W'(SEQDET_DEF_LEN);
            r_overlap <= SEQDET_DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else begin
            r_pattern <= w_pattern_n;
            r_len     <= w_len_n;
            r_overlap <= w_overlap_n;
            r_hist    <= w_hist_n;
            r_fill    <= w_fill_n;
            r_match   <= w_match_n;
        end
    end

    always_comb begin
        o_match = r_match;
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic w_cnt_en;

    assign w_cnt_en = w_accept && w_hit;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cnt_en),
        .i_clr (i_cfg_load),
        .o_cnt (o_match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector_param_moore.sv
// Bench for seq_detector_param_moore: directed scenarios plus random traffic against
// a queue-based model of "bits seen since the last restart point".
module tb_seq_detector_param_moore;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               x;
    logic               match;
`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit               m_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_match;
    int               m_cnt;

    seq_detector_param_moore #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cfg_load    (cfg_load),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_cfg_overlap (cfg_overlap),
        .i_in_valid    (in_valid),
        .i_x           (x),
        .o_match       (match)
`ifdef SEQDET_MATCH_CNT_EN
        ,
        .o_match_cnt   (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pat   = MAX_LEN'(4'b1001);
        m_len   = 4;
        m_ovl   = 1'b1;
        m_match = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic bit model_tail_matches();
        int base;
        if (m_q.size() < m_len) return 1'b0;
        base = m_q.size() - m_len;
        for (int i = 0; i < m_len; i++)
            if (m_q[base + i] != m_pat[m_len - 1 - i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_accept(input bit b);
        bit hit;
        m_q.push_back(b);
        while (m_q.size() > m_len) void'(m_q.pop_front());
        hit = model_tail_matches();
        m_match = hit;
        if (hit && m_cnt < CNT_MAX) m_cnt++;
        if (hit && !m_ovl) m_q.delete();
    endtask

    task automatic model_load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
        m_pat   = pat;
        m_len   = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
        m_ovl   = ovl;
        m_q.delete();
        m_match = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_match"}, 32'(match), 32'(m_match));
`ifdef SEQDET_MATCH_CNT_EN
        check_eq({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
`endif
    endtask

    // cfg_* are scrambled on non-load cycles; the DUT must ignore them.
    task automatic step(input string tag, input bit v, input bit b);
        cfg_load    = 1'b0;
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = LEN_W'($urandom);
        cfg_overlap = 1'($urandom);
        in_valid    = v;
        x           = b;
        @(posedge clk);
        if (v) model_accept(b);
        #1;
        check_outputs(tag);
    endtask

    task automatic load(input string tag, input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                        input bit v, input bit b);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        in_valid    = v;
        x           = b;
        @(posedge clk);
        model_load(pat, len, ovl);
        #1;
        cfg_load = 1'b0;
        check_outputs(tag);
    endtask

    task automatic feed(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(tag, 1'b1, bits[i]);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n       = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        x           = 1'b0;
        #2;
        do_reset("rst");

        // 1: default overlapping 1001, stream 1001001
        feed("t1", 32'b1001001, 7);

        // 2: non-overlap 1001
        load("t2_ld", 8'b1001, 4, 1'b0, 1'b0, 1'b0);
        feed("t2", 32'b1001001, 7);

        // 3: pattern 111, overlap then non-overlap
        load("t3a_ld", 8'b111, 3, 1'b1, 1'b0, 1'b0);
        feed("t3a", 32'b11111, 5);
        load("t3b_ld", 8'b111, 3, 1'b0, 1'b0, 1'b0);
        feed("t3b", 32'b11111, 5);

        // 4: stall holds a pending match
        load("t4_ld", 8'b1001, 4, 1'b1, 1'b0, 1'b0);
        feed("t4", 32'b1001, 4);
        for (int i = 0; i < 3; i++) step("t4_stall", 1'b0, 1'($urandom));
        step("t4_drop", 1'b1, 1'b0);

        // 5: bit coincident with cfg_load is dropped
        feed("t5_pre", 32'b100, 3);
        load("t5_ld", 8'b1001, 4, 1'b1, 1'b1, 1'b1);
        step("t5_nomatch", 1'b1, 1'b1);
        feed("t5_full", 32'b1001, 4);

        // 6: counter saturation with five overlapping hits, then len 0 -> 1
        load("t6_ld", 8'b1001, 4, 1'b1, 1'b0, 1'b0);
        feed("t6", 32'b1001001001001001, 16);
        load("t6_len0", 8'b1, 0, 1'b1, 1'b0, 1'b0);
        feed("t6_l1", 32'b1101, 4);
        load("t6_lenmax", 8'hA5, 15, 1'b1, 1'b0, 1'b0);
        feed("t6_l8", 32'hA5A5, 16);

        // mid-stream reset while a match is pending
        load("rst2_ld", 8'b1001, 4, 1'b1, 1'b0, 1'b0);
        feed("rst2_pre", 32'b1001, 4);
        check_eq("rst2_pending", 32'(match), 32'(1));
        do_reset("rst2");
        feed("rst2_post", 32'b001, 3);

        // random traffic; short patterns and 0/1-heavy streams to get real hits
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0)
                load("rnd_ld", MAX_LEN'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                     1'($urandom), 1'($urandom));
            else if ($urandom_range(0, 4) == 0)
                step("rnd_stall", 1'b0, 1'($urandom));
            else
                step("rnd", 1'b1, ($urandom_range(0, 3) != 0) ? m_pat[$urandom_range(0, m_len - 1)]
                                                             : 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
